// File: rtl/hall_call_dispatcher.sv
// Group dispatcher: latches hall calls into up/down slots and, one slot per cycle,
// hands each unassigned call to the nearest idle car until that car reports it served.
module hall_call_dispatcher #(
    parameter int FLOORS = 4,
    parameter int CARS   = 2,
    parameter int FW     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FLOORS-1:0]    up_press,
    input  logic [FLOORS-1:0]    down_press,
    input  logic [CARS*FW-1:0]   car_floor,
    input  logic [CARS-1:0]      car_done,
    output logic [CARS-1:0]      assign_valid,
    output logic [CARS*FW-1:0]   assign_floor,
    output logic [CARS-1:0]      assign_dir,
    output logic [FLOORS-1:0]    up_lamp,
    output logic [FLOORS-1:0]    down_lamp
);

    localparam int SLOTS = 2 * FLOORS;
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int OW    = (CARS > 1) ? $clog2(CARS) : 1;
    localparam logic [SW-1:0] FLOORS_S  = SW'(FLOORS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    logic [SLOTS-1:0] pending_r;
    logic [SLOTS-1:0] assigned_r;
    logic [OW-1:0]    owner_r [SLOTS];
    logic [SW-1:0]    scan_r;

    logic [SLOTS-1:0] press_s;
    logic [SLOTS-1:0] clear_s;
    logic [CARS-1:0]  done_eff_s;
    logic [CARS-1:0]  elig_s;
    logic [FW-1:0]    slot_floor_s;
    logic             slot_dir_s;
    logic [FW-1:0]    car_f_s;
    logic [FW:0]      cost_s;
    logic [FW:0]      best_cost_s;
    logic [OW-1:0]    best_car_s;
    logic             found_s;
    logic             grant_s;

    assign up_lamp   = pending_r[FLOORS-1:0];
    assign down_lamp = pending_r[SLOTS-1:FLOORS];

    // Qualify presses and car status; top-floor up and ground-floor down do not exist
    always_comb begin
        press_s           = {down_press, up_press};
        press_s[FLOORS-1] = 1'b0;
        press_s[FLOORS]   = 1'b0;
        done_eff_s        = car_done & assign_valid;
        elig_s            = ~assign_valid & ~car_done;
    end

    // A completing car releases whichever slot it owns
    always_comb begin
        clear_s = '0;
        for (int s = 0; s < SLOTS; s++) begin
            for (int c = 0; c < CARS; c++) begin
                clear_s[s] = clear_s[s] | (assigned_r[s] & done_eff_s[c] & (owner_r[s] == OW'(c)));
            end
        end
    end

    // Decode scanned slot and pick the nearest eligible car (strict < keeps lowest index on ties)
    always_comb begin
        if (scan_r < FLOORS_S) begin
            slot_floor_s = FW'(scan_r);
            slot_dir_s   = 1'b0;
        end else begin
            slot_floor_s = FW'(scan_r - FLOORS_S);
            slot_dir_s   = 1'b1;
        end
        car_f_s     = '0;
        cost_s      = '0;
        best_cost_s = '1;
        best_car_s  = '0;
        found_s     = 1'b0;
        for (int c = 0; c < CARS; c++) begin
            car_f_s = car_floor[c*FW +: FW];
            if ({1'b0, car_f_s} >= {1'b0, slot_floor_s}) begin
                cost_s = {1'b0, car_f_s} - {1'b0, slot_floor_s};
            end else begin
                cost_s = {1'b0, slot_floor_s} - {1'b0, car_f_s};
            end
            if (elig_s[c] && (!found_s || (cost_s < best_cost_s))) begin
                best_cost_s = cost_s;
                best_car_s  = OW'(c);
                found_s     = 1'b1;
            end else begin
                best_cost_s = best_cost_s;
            end
        end
        grant_s = pending_r[scan_r] & ~assigned_r[scan_r] & found_s;
    end

    // Scanner, slot state and per-car assignment registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_r       <= '0;
            pending_r    <= '0;
            assigned_r   <= '0;
            assign_valid <= '0;
            assign_floor <= '0;
            assign_dir   <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                owner_r[s] <= '0;
            end
        end else begin
            scan_r       <= (scan_r == LAST_SLOT) ? SW'(0) : scan_r + SW'(1);
            pending_r    <= (pending_r & ~clear_s) | press_s;
            assigned_r   <= assigned_r & ~clear_s;
            assign_valid <= assign_valid & ~done_eff_s;
            if (grant_s) begin
                assigned_r[scan_r]                <= 1'b1;
                owner_r[scan_r]                   <= best_car_s;
                assign_valid[best_car_s]          <= 1'b1;
                assign_floor[best_car_s*FW +: FW] <= slot_floor_s;
                assign_dir[best_car_s]            <= slot_dir_s;
            end
        end
    end

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed bench for hall_call_dispatcher: a per-cycle vector table from reset,
// followed by saturation, completion/press collision and asynchronous reset sequences.
module tb_hall_call_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] up_press, down_press;
    logic [3:0] car_floor;
    logic [1:0] car_done;
    logic [1:0] assign_valid;
    logic [3:0] assign_floor;
    logic [1:0] assign_dir;
    logic [3:0] up_lamp, down_lamp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] up;
        logic [3:0] dn;
        logic [1:0] done;
        logic [3:0] cf;
        logic [1:0] av;
        logic [3:0] af;
        logic [1:0] ad;
        logic [3:0] ul;
        logic [3:0] dl;
    } vec_t;

    vec_t vecs [17];

    hall_call_dispatcher #(.FLOORS(4), .CARS(2), .FW(2)) dut (
        .clk(clk), .reset(reset),
        .up_press(up_press), .down_press(down_press),
        .car_floor(car_floor), .car_done(car_done),
        .assign_valid(assign_valid), .assign_floor(assign_floor), .assign_dir(assign_dir),
        .up_lamp(up_lamp), .down_lamp(down_lamp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] av, input logic [3:0] af,
                             input logic [1:0] ad, input logic [3:0] ul, input logic [3:0] dl);
        check({tag, ".assign_valid"}, 32'(assign_valid), 32'(av));
        check({tag, ".assign_floor"}, 32'(assign_floor), 32'(af));
        check({tag, ".assign_dir"},   32'(assign_dir),   32'(ad));
        check({tag, ".up_lamp"},      32'(up_lamp),      32'(ul));
        check({tag, ".down_lamp"},    32'(down_lamp),    32'(dl));
    endtask

    // Drive one cycle of inputs, let one edge pass, then drop the pulses
    task automatic tick(input logic [3:0] u, input logic [3:0] d, input logic [1:0] dn);
        up_press   = u;
        down_press = d;
        car_done   = dn;
        @(posedge clk);
        #1;
        up_press   = 4'b0000;
        down_press = 4'b0000;
        car_done   = 2'b00;
    endtask

    initial begin
        int n;
        // Cycle i of the table sees scan pointer i mod 8.
        //            up       dn       done   cf       av     af       ad     ul       dl
        vecs[0]  = '{4'b0010, 4'b0000, 2'b00, 4'b1100, 2'b00, 4'b0000, 2'b00, 4'b0010, 4'b0000};
        vecs[1]  = '{4'b0000, 4'b0000, 2'b00, 4'b1100, 2'b01, 4'b0001, 2'b00, 4'b0010, 4'b0000};
        vecs[2]  = '{4'b0000, 4'b0100, 2'b00, 4'b1100, 2'b01, 4'b0001, 2'b00, 4'b0010, 4'b0100};
        vecs[3]  = '{4'b0000, 4'b0000, 2'b00, 4'b1100, 2'b01, 4'b0001, 2'b00, 4'b0010, 4'b0100};
        vecs[4]  = '{4'b0000, 4'b0000, 2'b00, 4'b1100, 2'b01, 4'b0001, 2'b00, 4'b0010, 4'b0100};
        vecs[5]  = '{4'b0000, 4'b0000, 2'b00, 4'b1100, 2'b01, 4'b0001, 2'b00, 4'b0010, 4'b0100};
        vecs[6]  = '{4'b0000, 4'b0000, 2'b00, 4'b1100, 2'b11, 4'b1001, 2'b10, 4'b0010, 4'b0100};
        vecs[7]  = '{4'b0000, 4'b0000, 2'b01, 4'b1100, 2'b10, 4'b1001, 2'b10, 4'b0000, 4'b0100};
        vecs[8]  = '{4'b1001, 4'b0001, 2'b10, 4'b1100, 2'b00, 4'b1001, 2'b10, 4'b0001, 4'b0000};
        vecs[9]  = '{4'b0000, 4'b0000, 2'b00, 4'b1010, 2'b00, 4'b1001, 2'b10, 4'b0001, 4'b0000};
        vecs[10] = '{4'b0000, 4'b0010, 2'b10, 4'b1010, 2'b00, 4'b1001, 2'b10, 4'b0001, 4'b0010};
        vecs[11] = '{4'b0000, 4'b0000, 2'b00, 4'b1010, 2'b00, 4'b1001, 2'b10, 4'b0001, 4'b0010};
        vecs[12] = '{4'b0000, 4'b0000, 2'b00, 4'b1010, 2'b00, 4'b1001, 2'b10, 4'b0001, 4'b0010};
        vecs[13] = '{4'b0000, 4'b0000, 2'b00, 4'b1010, 2'b01, 4'b1001, 2'b11, 4'b0001, 4'b0010};
        vecs[14] = '{4'b0000, 4'b0000, 2'b00, 4'b1010, 2'b01, 4'b1001, 2'b11, 4'b0001, 4'b0010};
        vecs[15] = '{4'b0000, 4'b0000, 2'b00, 4'b1010, 2'b01, 4'b1001, 2'b11, 4'b0001, 4'b0010};
        vecs[16] = '{4'b0000, 4'b0000, 2'b00, 4'b1010, 2'b11, 4'b0001, 2'b01, 4'b0001, 4'b0010};

        reset      = 1'b1;
        up_press   = 4'b0000;
        down_press = 4'b0000;
        car_done   = 2'b00;
        car_floor  = 4'b1100;
        @(posedge clk);
        #1;
        check_all("reset", 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            car_floor = vecs[i].cf;
            tick(vecs[i].up, vecs[i].dn, vecs[i].done);
            check_all($sformatf("vec%0d", i), vecs[i].av, vecs[i].af, vecs[i].ad, vecs[i].ul, vecs[i].dl);
        end

        // Saturation: both cars busy, new up call at floor 2 waits for a free car
        tick(4'b0100, 4'b0000, 2'b00);
        check_all("sat_press", 2'b11, 4'b0001, 2'b01, 4'b0101, 4'b0010);
        tick(4'b0000, 4'b0000, 2'b00);
        check_all("sat_noeligible", 2'b11, 4'b0001, 2'b01, 4'b0101, 4'b0010);
        tick(4'b0000, 4'b0000, 2'b10);
        check_all("sat_done1", 2'b01, 4'b0001, 2'b01, 4'b0100, 4'b0010);
        for (int i = 0; i < 6; i++) begin
            tick(4'b0000, 4'b0000, 2'b00);
        end
        check("sat_wait_sweep.assign_valid", 32'(assign_valid), 32'(2'b01));
        tick(4'b0000, 4'b0000, 2'b00);
        check_all("sat_regrant", 2'b11, 4'b1001, 2'b01, 4'b0100, 4'b0010);

        // Completion and a fresh press on the same slot in one cycle
        tick(4'b0100, 4'b0000, 2'b10);
        check_all("collide", 2'b01, 4'b1001, 2'b01, 4'b0100, 4'b0010);
        n = 0;
        while (!assign_valid[1] && n < 9) begin
            tick(4'b0000, 4'b0000, 2'b00);
            n++;
        end
        check("collide_latency", 32'(n), 32'd7);
        check_all("collide_regrant", 2'b11, 4'b1001, 2'b01, 4'b0100, 4'b0010);

        // Asynchronous reset with only car0 holding a call
        tick(4'b0000, 4'b0000, 2'b10);
        check_all("pre_reset", 2'b01, 4'b1001, 2'b01, 4'b0000, 4'b0010);
        #3;
        reset = 1'b1;
        #1;
        check_all("async_reset", 2'b00, 4'b0000, 2'b00, 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(4'b0010, 4'b0000, 2'b00);
        check_all("post_reset_press", 2'b00, 4'b0000, 2'b00, 4'b0010, 4'b0000);
        tick(4'b0000, 4'b0000, 2'b00);
        check_all("post_reset_scan1", 2'b01, 4'b0001, 2'b00, 4'b0010, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
